adventure_game_player: RTL and testbench
========================================

Name: adventure_game_player

Overview:
- Autonomous player that drives the adventure game's command inputs (start, direction) and observes its outputs (room, sword, result).
- Replays a parameterised route of moves, checks each resulting room, and enforces a per-move timeout.
- Reports win or fail.
- Sits beside the game top level on the board and replaces manual switches for self-test and demo.

Parameters:
ROUTE_LEN, 4, number of valid route entries (1..8)
ROUTE_DIR, 16'h0000, packed 2-bit directions; entry i at bits [2i+1:2i]
ROUTE_ROOM, 24'h000000, packed 3-bit expected room after move i; entry i at bits [3i+2:3i]
TIMEOUT, 16, cycles allowed for room to change after a direction is driven (>=2)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
go  in  1  request a run; sampled in IDLE only
room_in  in  3  current room from game
sword_in  in  1  sword held flag from game
result_in  in  1  game result (win) from game
game_start  out  1  start pulse to game
direction  out  2  move direction to game
busy  out  1  run in progress
done  out  1  run finished; high until next go
win  out  1  valid when done: 1 = result_in seen after last move
fail  out  1  valid when done: 1 = wrong room or timeout
step  out  3  index of the current/last route entry

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; game_start=0, direction=2'b00, busy=0, done=0, win=0, fail=0, step=0, timer=0. Reset mid-run aborts immediately with no completion flags.
- All outputs are registered.
- States: IDLE, START, SETTLE, MOVE, NEXT, FINISH.
- IDLE: on go=1 -> START.
  - Clears done/win/fail and step.
  - busy=1 from the next cycle.
  - go while busy is ignored.
- START: game_start=1 for exactly one cycle -> SETTLE.
- SETTLE: one cycle. Latch room_in as prev_room -> MOVE.
- MOVE:
  - direction = ROUTE_DIR[step]; timer increments each cycle.
  - If room_in != prev_room:
    - room_in == ROUTE_ROOM[step] -> NEXT.
    - Otherwise -> FINISH with fail=1.
  - If timer reaches TIMEOUT-1 with no room change -> FINISH with fail=1.
- NEXT: latch prev_room=room_in, clear timer.
  - If step == ROUTE_LEN-1 -> FINISH.
  - Else step+1 -> MOVE.
- FINISH:
  - busy=0, done=1.
  - win = result_in sampled on entry, only if fail=0.
  - fail and win are never both 1.
  - Direction holds its last value.
  - -> IDLE, where done/win/fail hold until the next go.
- Simultaneous events: a room change and the timeout in the same cycle count as a room change.
  - result_in asserting before the last step is ignored.
  - The step counter never wraps: it saturates at ROUTE_LEN-1.
- Latency: go -> game_start is 1 cycle. Final room match -> done is 2 cycles.

Optional Feature:
- Macro: ADV_PLAYER_SWORD_CHECK_EN.
- Defined:
  - On entry to MOVE for the last route entry, if sword_in=0 -> FINISH with fail=1; the last direction is never driven.
  - On FINISH with win=0 and fail=0 (result_in low after the last move), fail is forced to 1.
- Not defined:
  - sword_in is unused.
  - A run may end with done=1, win=0, fail=0 (route completed, game not won).

Test Plan:
- Reset mid-MOVE at step 2 -> all outputs zero within the same cycle; next go restarts at step 0 with one game_start pulse.
- Win: ROUTE_LEN=3, ROUTE_DIR={E,S,W}, ROUTE_ROOM={1,3,6}. Game model changes room 2 cycles after each direction; result_in=1 at room 6 -> done=1, win=1, fail=0, step=2.
- Wrong room: the model returns room 5 where room 3 is expected at step 1 -> done=1, fail=1, win=0, step=1; direction is not advanced.
- Timeout: TIMEOUT=16 and the model never changes room -> fail=1 exactly 16 cycles after MOVE entry.
- Ignored go: go pulsed while busy=1 -> no second game_start; the run completes normally.
- Sword gate (ADV_PLAYER_SWORD_CHECK_EN defined): sword_in=0 at the last step -> fail=1, and the last direction is never driven. With sword_in=1 -> win=1.

Source files
------------

// File: rtl/adventure_game_player.sv
// Autonomous route player: drives start/direction, checks rooms, reports win/fail.
// Optional build macro ADV_PLAYER_SWORD_CHECK_EN gates the last move on sword_in.
module adventure_game_player #(
    parameter int unsigned ROUTE_LEN  = 4,
    parameter logic [15:0] ROUTE_DIR  = 16'h0000,
    parameter logic [23:0] ROUTE_ROOM = 24'h000000,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       go,
    input  logic [2:0] room_in,
    input  logic       sword_in,
    input  logic       result_in,
    output logic       game_start,
    output logic [1:0] direction,
    output logic       busy,
    output logic       done,
    output logic       win,
    output logic       fail,
    output logic [2:0] step
);

    localparam logic [2:0]  LAST = 3'(ROUTE_LEN - 1);
    localparam logic [15:0] TMAX = 16'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        SETTLE,
        MOVE,
        NEXT,
        FINISH
    } state_t;

    state_t      state;
    logic [2:0]  prev_room;
    logic [15:0] timer;

    logic [2:0]  step_inc;
    logic [1:0]  dir_cur;
    logic [1:0]  dir_nxt;
    logic [4:0]  room_idx;
    logic [2:0]  room_exp;

    // step saturates at the last route entry
    assign step_inc = (step == LAST) ? step : step + 3'd1;
    assign dir_cur  = ROUTE_DIR[{step, 1'b0} +: 2];
    assign dir_nxt  = ROUTE_DIR[{step_inc, 1'b0} +: 2];
    assign room_idx = {2'b00, step} * 5'd3;
    assign room_exp = ROUTE_ROOM[room_idx +: 3];

`ifndef ADV_PLAYER_SWORD_CHECK_EN
    logic unused_sword;
    assign unused_sword = sword_in;
`endif

    // Run sequencer; every output is a register updated here
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            game_start <= 1'b0;
            direction  <= 2'b00;
            busy       <= 1'b0;
            done       <= 1'b0;
            win        <= 1'b0;
            fail       <= 1'b0;
            step       <= 3'd0;
            timer      <= 16'd0;
            prev_room  <= 3'd0;
        end else begin
            game_start <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (go) begin
                        state      <= START;
                        game_start <= 1'b1;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        win        <= 1'b0;
                        fail       <= 1'b0;
                        step       <= 3'd0;
                        timer      <= 16'd0;
                    end
                end
                START: begin
                    state <= SETTLE;
                end
                SETTLE: begin
                    prev_room <= room_in;
                    timer     <= 16'd0;
`ifdef ADV_PLAYER_SWORD_CHECK_EN
                    if (LAST == 3'd0 && !sword_in) begin
                        state <= FINISH;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        fail  <= 1'b1;
                    end else begin
                        state     <= MOVE;
                        direction <= dir_cur;
                    end
`else
                    state     <= MOVE;
                    direction <= dir_cur;
`endif
                end
                MOVE: begin
                    // a room change wins over a timeout in the same cycle
                    if (room_in != prev_room) begin
                        if (room_in == room_exp) begin
                            state <= NEXT;
                        end else begin
                            state <= FINISH;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            fail  <= 1'b1;
                        end
                    end else if (timer == TMAX) begin
                        state <= FINISH;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        fail  <= 1'b1;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                NEXT: begin
                    prev_room <= room_in;
                    timer     <= 16'd0;
                    if (step == LAST) begin
                        state <= FINISH;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        win   <= result_in;
`ifdef ADV_PLAYER_SWORD_CHECK_EN
                        fail  <= !result_in;
`endif
                    end else begin
                        step <= step_inc;
`ifdef ADV_PLAYER_SWORD_CHECK_EN
                        if (step_inc == LAST && !sword_in) begin
                            state <= FINISH;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            fail  <= 1'b1;
                        end else begin
                            state     <= MOVE;
                            direction <= dir_nxt;
                        end
`else
                        state     <= MOVE;
                        direction <= dir_nxt;
`endif
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adventure_game_player.sv
// Randomized bench for adventure_game_player with a schedule-level game model.
// Route: E,S,W into rooms 1,3,6; game starts in room 0.
module tb_adventure_game_player;

    localparam int          LEN   = 3;
    localparam logic [15:0] RDIR  = 16'h0039;
    localparam logic [23:0] RROOM = 24'h000199;
    localparam int          TO    = 16;
    localparam int          K_OK  = 0;
    localparam int          K_WR  = 1;
    localparam int          K_TO  = 2;
`ifdef ADV_PLAYER_SWORD_CHECK_EN
    localparam bit SWORD = 1'b1;
`else
    localparam bit SWORD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       go = 1'b0;
    logic [2:0] room_in = 3'd0;
    logic       sword_in = 1'b1;
    logic       result_in = 1'b0;
    logic       game_start;
    logic [1:0] direction;
    logic       busy;
    logic       done;
    logic       win;
    logic       fail;
    logic [2:0] step;

    adventure_game_player #(
        .ROUTE_LEN (LEN),
        .ROUTE_DIR (RDIR),
        .ROUTE_ROOM(RROOM),
        .TIMEOUT   (TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .go        (go),
        .room_in   (room_in),
        .sword_in  (sword_in),
        .result_in (result_in),
        .game_start(game_start),
        .direction (direction),
        .busy      (busy),
        .done      (done),
        .win       (win),
        .fail      (fail),
        .step      (step)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int gs_total = 0;
    always @(negedge clk) if (game_start) gs_total++;

    logic [1:0] dir_of  [0:2] = '{2'd1, 2'd2, 2'd3};
    logic [2:0] room_of [0:2] = '{3'd1, 3'd3, 3'd6};

    int         mdl_d  [0:2];
    int         mdl_ch [0:2];
    int         mdl_m  [0:2];
    logic [2:0] mdl_rm [0:2];
    int         exp_done;
    logic [2:0] exp_step;
    logic [1:0] exp_dir;
    bit         exp_win;
    bit         exp_fail;

    logic [1:0] tr_dir  [0:79];
    logic [2:0] tr_step [0:79];
    int         done_at;
    int         gs_cnt;
    logic [9:0] ab_out;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // schedule model: MOVE for step 0 begins 2 cycles after go is taken
    task automatic model(input int kind, input int bad, input bit res);
        int t;
        t = 2;
        for (int i = 0; i < 3; i++) begin
            mdl_ch[i] = -1;
            mdl_m[i]  = -1;
            mdl_rm[i] = room_of[i];
        end
        exp_win  = 1'b0;
        exp_fail = 1'b1;
        exp_done = -1;
        exp_step = 3'd0;
        exp_dir  = dir_of[0];
        for (int i = 0; i < LEN; i++) begin
            mdl_m[i] = t;
            exp_step = 3'(i);
            exp_dir  = dir_of[i];
            if (kind == K_TO && i == bad) begin
                exp_done = t + TO;
                return;
            end
            mdl_ch[i] = t + mdl_d[i];
            if (kind == K_WR && i == bad) begin
                mdl_rm[i] = room_of[i] ^ 3'd4;
                exp_done  = t + mdl_d[i] + 1;
                return;
            end
            if (i == LEN - 1) begin
                exp_done = t + mdl_d[i] + 2;
                exp_win  = res;
                exp_fail = SWORD && !res;
            end else begin
                t = t + mdl_d[i] + 2;
            end
        end
    endtask

    // game environment: rooms change at scheduled cycles after go
    task automatic play(input bit res, input int res_from,
                        input int go_at, input int abort_at);
        int gs_base;
        room_in   = 3'd0;
        result_in = 1'b0;
        done_at   = -1;
        ab_out    = '1;
        gs_base   = gs_total;
        go = 1'b1;
        tick();
        go = 1'b0;
        for (int c = 0; c < 80; c++) begin
            tr_dir[c]  = direction;
            tr_step[c] = step;
            if (done) begin
                done_at = c;
                break;
            end
            if (c == abort_at) begin
                reset = 1'b0;
                #1;
                ab_out = {game_start, direction, busy, done, win, fail, step};
                #2;
                reset = 1'b1;
                break;
            end
            for (int i = 0; i < 3; i++) begin
                if (mdl_ch[i] == c) begin
                    room_in = mdl_rm[i];
                    if (res && i >= res_from) result_in = 1'b1;
                end
            end
            go = (c == go_at);
            tick();
        end
        go = 1'b0;
        tick();
        gs_cnt = gs_total - gs_base;
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if ({game_start, direction, busy, done, win, fail, step} !== 10'd0) begin
            errors++;
            $display("FAIL reset_hold: got %b want 0",
                     {game_start, direction, busy, done, win, fail, step});
        end
        #3 reset = 1'b1;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || step !== 3'd0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b done=%b step=%0d want 0 0 0",
                     busy, done, step);
        end
        checks++;
        if (game_start !== 1'b0 || direction !== 2'd0) begin
            errors++;
            $display("FAIL reset_cmd: gs=%b dir=%0d want 0 0", game_start, direction);
        end
    endtask

    task automatic test_win;
        mdl_d = '{2, 2, 2};
        model(K_OK, 0, 1'b1);
        play(1'b1, 2, -1, -1);
        checks++;
        if (done_at !== 14) begin
            errors++;
            $display("FAIL win_latency: got %0d want 14", done_at);
        end
        checks++;
        if ({done, win, fail, busy} !== 4'b1100) begin
            errors++;
            $display("FAIL win_flags: done/win/fail/busy=%b want 1100",
                     {done, win, fail, busy});
        end
        checks++;
        if (step !== 3'd2) begin
            errors++;
            $display("FAIL win_step: got %0d want 2", step);
        end
        checks++;
        if (gs_cnt !== 1) begin
            errors++;
            $display("FAIL win_start_pulses: got %0d want 1", gs_cnt);
        end
        for (int i = 0; i < LEN; i++) begin
            checks++;
            if (tr_dir[mdl_m[i]] !== dir_of[i] || tr_step[mdl_m[i]] !== 3'(i)) begin
                errors++;
                $display("FAIL win_move%0d: dir=%0d step=%0d want %0d %0d", i,
                         tr_dir[mdl_m[i]], tr_step[mdl_m[i]], dir_of[i], i);
            end
        end
    endtask

    task automatic test_wrong_room;
        mdl_d = '{2, 2, 2};
        model(K_WR, 1, 1'b1);
        mdl_rm[1] = 3'd5;
        play(1'b1, 0, -1, -1);
        checks++;
        if (done_at !== exp_done) begin
            errors++;
            $display("FAIL wrong_latency: got %0d want %0d", done_at, exp_done);
        end
        checks++;
        if ({done, win, fail} !== 3'b101 || step !== 3'd1) begin
            errors++;
            $display("FAIL wrong_flags: d/w/f=%b step=%0d want 101 1",
                     {done, win, fail}, step);
        end
        checks++;
        if (direction !== dir_of[1]) begin
            errors++;
            $display("FAIL wrong_dir: got %0d want %0d", direction, dir_of[1]);
        end
    endtask

    task automatic test_timeout;
        mdl_d = '{2, 2, 2};
        model(K_TO, 0, 1'b0);
        play(1'b0, 0, -1, -1);
        checks++;
        if (done_at !== 18) begin
            errors++;
            $display("FAIL timeout_latency: got %0d want 18", done_at);
        end
        checks++;
        if ({done, win, fail} !== 3'b101 || step !== 3'd0) begin
            errors++;
            $display("FAIL timeout_flags: d/w/f=%b step=%0d want 101 0",
                     {done, win, fail}, step);
        end
    endtask

    task automatic test_ignored_go;
        mdl_d = '{2, 2, 2};
        model(K_OK, 0, 1'b1);
        play(1'b1, 2, 5, -1);
        checks++;
        if (gs_cnt !== 1) begin
            errors++;
            $display("FAIL igo_pulses: got %0d want 1", gs_cnt);
        end
        checks++;
        if (done_at !== 14 || win !== 1'b1 || fail !== 1'b0) begin
            errors++;
            $display("FAIL igo_run: done_at=%0d win=%b fail=%b want 14 1 0",
                     done_at, win, fail);
        end
    endtask

    task automatic test_reset_mid_move;
        mdl_d = '{2, 2, 2};
        model(K_OK, 0, 1'b1);
        play(1'b1, 2, -1, 11);
        checks++;
        if (tr_step[11] !== 3'd2) begin
            errors++;
            $display("FAIL rmid_at_step: got %0d want 2", tr_step[11]);
        end
        checks++;
        if (ab_out !== 10'd0) begin
            errors++;
            $display("FAIL rmid_outputs: got %b want 0", ab_out);
        end
        play(1'b1, 2, -1, -1);
        checks++;
        if (gs_cnt !== 1 || tr_step[2] !== 3'd0 || tr_dir[2] !== dir_of[0]) begin
            errors++;
            $display("FAIL rmid_restart: gs=%0d step=%0d dir=%0d want 1 0 %0d",
                     gs_cnt, tr_step[2], tr_dir[2], dir_of[0]);
        end
        checks++;
        if (done_at !== 14 || win !== 1'b1) begin
            errors++;
            $display("FAIL rmid_rerun: done_at=%0d win=%b want 14 1", done_at, win);
        end
    endtask

`ifdef ADV_PLAYER_SWORD_CHECK_EN
    task automatic test_sword;
        bit west;
        mdl_d = '{2, 2, 2};
        model(K_OK, 0, 1'b1);
        sword_in = 1'b0;
        play(1'b1, 2, -1, -1);
        sword_in = 1'b1;
        west = 1'b0;
        for (int c = 0; c < 80; c++) begin
            if (c <= done_at && tr_dir[c] == dir_of[2]) west = 1'b1;
        end
        checks++;
        if (done_at !== 10 || {win, fail} !== 2'b01) begin
            errors++;
            $display("FAIL sword_gate: done_at=%0d win/fail=%b want 10 01",
                     done_at, {win, fail});
        end
        checks++;
        if (west !== 1'b0 || direction !== dir_of[1]) begin
            errors++;
            $display("FAIL sword_dir: last_seen=%b dir=%0d want 0 %0d",
                     west, direction, dir_of[1]);
        end
        play(1'b1, 2, -1, -1);
        checks++;
        if (done_at !== 14 || {win, fail} !== 2'b10) begin
            errors++;
            $display("FAIL sword_win: done_at=%0d win/fail=%b want 14 10",
                     done_at, {win, fail});
        end
    endtask
`endif

    task automatic test_random;
        int  kind;
        int  bad;
        bit  res;
        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < 3; i++) begin
                mdl_d[i] = ($urandom_range(0, 3) == 0) ? 15 : int'($urandom_range(0, 6));
            end
            kind = int'($urandom_range(0, 2));
            bad  = int'($urandom_range(0, 2));
            res  = 1'($urandom_range(0, 1));
            model(kind, bad, res);
            play(res, int'($urandom_range(0, 2)), int'($urandom_range(0, 40)), -1);
            checks++;
            if (done_at !== exp_done) begin
                errors++;
                $display("FAIL rnd%0d_latency: got %0d want %0d", n, done_at, exp_done);
            end
            checks++;
            if ({done, win, fail, busy} !== {1'b1, exp_win, exp_fail, 1'b0}) begin
                errors++;
                $display("FAIL rnd%0d_flags: d/w/f/b=%b want %b", n,
                         {done, win, fail, busy}, {1'b1, exp_win, exp_fail, 1'b0});
            end
            checks++;
            if (step !== exp_step || direction !== exp_dir) begin
                errors++;
                $display("FAIL rnd%0d_pos: step=%0d dir=%0d want %0d %0d", n,
                         step, direction, exp_step, exp_dir);
            end
            checks++;
            if (gs_cnt !== 1) begin
                errors++;
                $display("FAIL rnd%0d_pulses: got %0d want 1", n, gs_cnt);
            end
            for (int i = 0; i < 3; i++) begin
                if (mdl_m[i] >= 0) begin
                    checks++;
                    if (tr_dir[mdl_m[i]] !== dir_of[i]) begin
                        errors++;
                        $display("FAIL rnd%0d_move%0d: dir=%0d want %0d", n, i,
                                 tr_dir[mdl_m[i]], dir_of[i]);
                    end
                end
            end
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        test_reset();
        test_win();
        test_wrong_room();
        test_timeout();
        test_ignored_go();
        test_reset_mid_move();
`ifdef ADV_PLAYER_SWORD_CHECK_EN
        test_sword();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
